// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// the fetch FSM state encoding and a small state-classification helper.
package fetch_pkg;

  localparam int FETCH_ADDR_W      = 8;
  localparam int FETCH_DATA_W      = 8;
  localparam int FETCH_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // True in the states where a memory bus cycle is outstanding.
  function automatic logic is_bus_state(input fetch_state_t s);
    return (s == REQ) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait counter for outstanding memory reads. It is cleared by the owner on
// entry to a waiting state and counts every waiting cycle without an ack.
// expire is combinational: it is high in the cycle where the counter already
// holds LIMIT-1 and the cycle is still a waiting cycle, so an ack arriving on
// the LIMIT-th waiting cycle still wins.
module fetch_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count waiting cycles, saturating at LAST so it never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: consumer end of the program-counter interface.
// Samples pc_in, reads program memory over a req/ack handshake, offers the
// returned byte to the decoder over valid/ready and pulses pc_inc once per
// completed fetch. flush discards a held or in-flight instruction; a bus cycle
// already issued is always completed (DRAIN) rather than cancelled.
// Optional feature macro: FETCH_TIMEOUT_EN adds a memory-ack timeout with a
// sticky fetch_err flag; without it fetch_err is tied low and the unit waits
// indefinitely for mem_ack.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = FETCH_ADDR_W,
  parameter int DATA_W      = FETCH_DATA_W,
  parameter int TIMEOUT_CYC = FETCH_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              fetch_err
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT_CYC must be at least 2");
  end

  fetch_state_t state;
  logic         timeout;
  logic         fetch_block;

`ifdef FETCH_TIMEOUT_EN
  logic fetch_err_q;
  logic ctr_clear;
  logic ctr_enable;

  assign ctr_clear  = !is_bus_state(state) || ((state == REQ) && flush && !mem_ack);
  assign ctr_enable = is_bus_state(state) && !mem_ack;

  fetch_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (ctr_clear),
    .enable(ctr_enable),
    .expire(timeout)
  );

  // Sticky error flag: set by a timeout, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err_q <= 1'b0;
    end else if (timeout) begin
      fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err   = fetch_err_q;
  assign fetch_block = fetch_err_q;
`else
  assign timeout     = 1'b0;
  assign fetch_block = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // Fetch FSM with all outputs registered; pc_inc defaults low so it can only
  // ever be a single-cycle pulse on the REQ->HOLD transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      pc_inc      <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_addr  <= '0;
    end else begin
      pc_inc <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_en && !flush && !fetch_block) begin
            mem_addr <= pc_in;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (mem_ack && !flush) begin
            instr_out   <= mem_rdata;
            instr_addr  <= mem_addr;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            pc_inc      <= 1'b1;
            state       <= HOLD;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (flush || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        DRAIN: begin
          if (timeout || mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Consumer end of the program-counter interface.
- Samples the PC value and issues a read to program memory over a req/ack handshake.
- Latches the returned byte as the current instruction and offers it to the decoder over a valid/ready handshake.
- Pulses pc_inc one cycle so the PC advances.
- Supports a synchronous flush so the branch logic can discard in-flight fetches.

Parameters:
- ADDR_W, 8, PC and memory address width.
- DATA_W, 8, instruction and memory data width.
- TIMEOUT_CYC, 16, cycles to wait for mem_ack before declaring an error (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  allows a new fetch to start from IDLE.
- flush  input  1  discard the held or in-flight instruction (branch taken).
- pc_in  input  ADDR_W  current program counter value.
- pc_inc  output  1  one-cycle pulse requesting PC increment.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W  memory read address.
- mem_ack  input  1  memory read complete; mem_rdata is valid in this cycle.
- mem_rdata  input  DATA_W  memory read data.
- instr_valid  output  1  instr_out and instr_addr are valid.
- instr_ready  input  1  decoder accepts the instruction.
- instr_out  output  DATA_W  fetched instruction.
- instr_addr  output  ADDR_W  address the instruction came from.
- fetch_err  output  1  sticky timeout error (0 when FETCH_TIMEOUT_EN is not defined).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Reset has priority over all inputs.
- Reset values: state=IDLE; all outputs 0 (mem_req, mem_addr, pc_inc, instr_valid, instr_out, instr_addr, fetch_err).
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE:
  - If fetch_en && !flush: mem_addr<=pc_in, mem_req<=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req and mem_addr are held stable until mem_ack is sampled high.
  - fetch_en dropping does not abort the request.
  - mem_ack && !flush: instr_out<=mem_rdata, instr_addr<=mem_addr, instr_valid<=1, mem_req<=0, pc_inc<=1 for exactly one cycle, go to HOLD.
  - flush && !mem_ack: go to DRAIN; mem_req stays high because a bus cycle is never cancelled.
  - flush && mem_ack in the same cycle: data discarded, mem_req<=0, no pc_inc, go to IDLE.
- HOLD:
  - instr_out and instr_addr stay stable while instr_valid=1 && !instr_ready.
  - instr_valid && instr_ready: instr_valid<=0, go to IDLE.
  - flush (with or without ready): instr_valid<=0, go to IDLE. The earlier pc_inc is not undone; the branch logic reloads the PC.
- DRAIN:
  - mem_req stays high until mem_ack; mem_rdata is ignored.
  - On mem_ack: mem_req<=0, go to IDLE. No pc_inc, no instr_valid.
  - flush while in DRAIN has no extra effect.
- Return through IDLE is mandatory. pc_inc updates the PC at the edge after the pulse, so pc_in is sampled only after the PC has settled.
  - Minimum cost per instruction: 3 cycles plus memory latency.
- pc_inc is never asserted in two consecutive cycles.
- mem_ack outside REQ/DRAIN is ignored.
- Address wrap (0xFF to 0x00) is the PC's concern; mem_addr is a plain copy of pc_in.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to REQ or DRAIN and increments each cycle without mem_ack.
  - Timeout triggers when the counter reaches TIMEOUT_CYC-1 with no ack in that cycle, so mem_ack on the TIMEOUT_CYC-th waiting cycle still completes normally.
  - On timeout: mem_req<=0, fetch_err<=1 (sticky until reset), no pc_inc, go to IDLE.
  - While fetch_err=1 the IDLE state ignores fetch_en.
- Not defined: no counter; fetch_err is tied to 0; the unit waits indefinitely.

Decomposition:
- Shared package fetch_pkg holds ADDR_W/DATA_W defaults and the state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3).
- One natural sub-module, fetch_timeout_ctr: counter with clear, enable and expire outputs. It is instantiated only under FETCH_TIMEOUT_EN.
- The FSM and datapath registers stay in instr_fetch_unit.

Test Plan:
1. Basic fetch: reset, pc_in=0x05, fetch_en=1, memory acks after 2 cycles with 0xA3 -> mem_addr=0x05 held through the wait; instr_out=0xA3, instr_addr=0x05; instr_valid rises the cycle after ack; single pc_inc pulse.
2. Decoder backpressure: instr_ready=0 for 4 cycles -> instr_valid and instr_out=0xA3 stable for all 4; on ready=1, valid drops next cycle; the next fetch samples pc_in=0x06.
3. Flush in REQ: flush in the cycle after the request issues, ack 3 cycles later with 0x7E -> mem_req stays high until ack; instr_valid never rises; no pc_inc; next fetch starts from IDLE.
4. Simultaneous flush and mem_ack -> no instr_valid, no pc_inc, mem_req=0 next cycle, state IDLE.
5. Reset mid-operation: assert reset in HOLD with instr_valid=1 -> all outputs 0 and state IDLE at the next edge; ack/ready arriving during reset are ignored.
6. Timeout (FETCH_TIMEOUT_EN, TIMEOUT_CYC=16): memory never acks -> mem_req drops after 16 waiting cycles; fetch_err=1 stays set; fetch_en is then ignored. A separate run with ack on cycle 16 completes normally with fetch_err=0.
